// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants and helpers for the instruction fetch unit.
package inst_fetch_pkg;
    localparam int unsigned MEM_ADDR_WIDTH_DEF = 10;
    localparam int unsigned INST_WIDTH_DEF = 32;
    localparam int unsigned INST_MEM_SIZE_DEF = 1024;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef logic [31:0] pc_t;

    // Full 30-bit word index compare so out-of-range PCs never alias into memory.
    function automatic logic pc_fault(input pc_t pc, input int unsigned size);
        return {2'b00, pc[31:2]} >= 32'(size);
    endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry in-order FIFO with flush; head reads zero when empty.
module fetch_skid_buf #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] e0, e1, e0_n, e1_n;
    logic [1:0]   count_n;

    always_comb begin
        count_n = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
        e0_n = (pop && count == 2'd2) ? e1 :
               (push && (count == 2'd0 || (pop && count == 2'd1))) ? din : e0;
        e1_n = (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) ? din : e1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            count <= count_n;
            e0    <= e0_n;
            e1    <= e1_n;
        end
    end

    assign head = (count != 2'd0) ? e0 : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && count == 2'd2));
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and fetch initiator for inst_mem with a credit-limited
// 2-entry return queue and valid/ready delivery to decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
    parameter int unsigned INST_WIDTH     = INST_WIDTH_DEF,
    parameter int unsigned INST_MEM_SIZE  = INST_MEM_SIZE_DEF,
    parameter logic [31:0] RESET_PC       = RESET_PC_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
    input  logic [INST_WIDTH-1:0]     i_MemData,
    input  logic                      i_Redirect,
    input  logic [31:0]               i_RedirectPc,
    output logic                      o_Valid,
    input  logic                      i_Ready,
    output logic [INST_WIDTH-1:0]     o_Inst,
    output logic [31:0]               o_Pc,
    output logic                      o_Fault
);
    localparam int unsigned W = 33 + INST_WIDTH;

    pc_t                  pc, req_pc, a;
    logic                 inflight, issue, pop, push, fault;
    logic [2:0]           credit;
    logic [1:0]           count;
    logic [W-1:0]         head;
    logic [INST_WIDTH-1:0] data;

    always_comb begin
        a      = i_Redirect ? (i_RedirectPc & ~32'h3) : pc;
        pop    = o_Valid & i_Ready;
        // Outstanding slots: queued + in flight, minus what decode takes this cycle.
        credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue  = i_Redirect | (credit < 3'd2);
        push   = inflight & ~i_Redirect;
        fault  = pc_fault(req_pc, INST_MEM_SIZE);
        data   = fault ? INST_WIDTH'(NOP_INST) : i_MemData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= a + 32'd4;
                req_pc <= a;
            end
        end
    end

    fetch_skid_buf #(.W(W)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (i_Redirect),
        .din   ({fault, req_pc, data}),
        .count (count),
        .head  (head)
    );

    assign o_MemAddr = reset ? RESET_PC[MEM_ADDR_WIDTH+1:2] : a[MEM_ADDR_WIDTH+1:2];
    assign o_Valid   = (count != 2'd0) & ~i_Redirect;
    assign o_Fault   = head[W-1];
    assign o_Pc      = head[W-2:INST_WIDTH];
    assign o_Inst    = head[INST_WIDTH-1:0];
endmodule
